// File: rtl/xsz_split.sv
// Wide-to-narrow request splitter: one wide request in, one narrow beat per
// lane with non-zero strobes out (a read issues a single beat for the addressed lane).
module xsz_split #(
    parameter int AW  = 19,
    parameter int DWI = 64,
    parameter int DWO = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_vld_s,
    output logic               req_rdy_s,
    input  logic [AW-1:0]      req_adr_s,
    input  logic [DWI-1:0]     req_dat_s,
    input  logic [DWI/8-1:0]   req_strb_s,
    output logic               req_vld_m,
    input  logic               req_rdy_m,
    output logic [AW-1:0]      req_adr_m,
    output logic [DWO-1:0]     req_dat_m,
    output logic [DWO/8-1:0]   req_strb_m,
    output logic               busy
);

    localparam int N  = DWI / DWO;
    localparam int SW = DWO / 8;
    localparam int LO = $clog2(SW);
    localparam int HI = $clog2(DWI / 8);
    localparam int LW = HI - LO;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      adr_q;
    logic [DWI-1:0]     dat_q;
    logic [DWI/8-1:0]   strb_q;
    logic               rd_q;
    logic [N-1:0]       pend;
    logic [N-1:0]       new_pend;
    logic [LW-1:0]      lane;
    logic               last;
    logic               s_hs;
    logic               m_hs;

    assign s_hs = req_vld_s & req_rdy_s;
    assign m_hs = req_vld_m & req_rdy_m;

    // Current lane is the lowest pending one; the descending loop lets it win.
    always_comb begin
        lane = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend[i]) lane = LW'(i);
        end
    end

    assign last = (pend != '0) && ((pend & (pend - ONE)) == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        new_pend = '0;
        if (req_strb_s == '0) begin
            new_pend[req_adr_s[HI-1:LO]] = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                new_pend[i] = |req_strb_s[i*SW +: SW];
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (s_hs) state_nxt = SEND;
            SEND: if (m_hs && last && !s_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beats come only from registered state; req_vld_s never reaches req_vld_m.
    always_comb begin
        busy       = (state == SEND);
        req_vld_m  = (state == SEND);
        req_rdy_s  = !rst && ((state == IDLE) || ((state == SEND) && req_rdy_m && last));
        req_adr_m  = '0;
        req_dat_m  = '0;
        req_strb_m = '0;
        if (state == SEND) begin
            req_dat_m = dat_q[int'(lane)*DWO +: DWO];
            if (rd_q) begin
                req_adr_m = adr_q;
            end else begin
                req_adr_m  = {adr_q[AW-1:HI], {HI{1'b0}}} | (AW'(lane) << LO);
                req_strb_m = strb_q[int'(lane)*SW +: SW];
            end
        end
    end

    // NOTE: payload registers are reset with the control state so nothing stale survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q  <= '0;
            dat_q  <= '0;
            strb_q <= '0;
            rd_q   <= 1'b0;
            pend   <= '0;
        end else if (s_hs) begin
            adr_q  <= req_adr_s;
            dat_q  <= req_dat_s;
            strb_q <= req_strb_s;
            rd_q   <= (req_strb_s == '0);
            pend   <= new_pend;
        end else if (m_hs) begin
            pend   <= pend & ~(ONE << lane);
        end
    end

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (req_vld_m && !req_rdy_m) |=> (req_vld_m && $stable(req_adr_m)
                                       && $stable(req_dat_m) && $stable(req_strb_m)));

    a_pend: assert property (@(posedge clk) disable iff (rst)
        (state == SEND) |-> (pend != '0));

endmodule
